// File: rtl/afifo_pkg.sv
// ============================================================================
// afifo_pkg : shared constants, state type and helpers for the FIFO write arbiter
// Revision  : 1.0
// ============================================================================
`default_nettype none

package afifo_pkg;

   localparam int c_NREQ  = 4;
   localparam int c_DW    = 8;
   localparam int c_BURST = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Index width for n requesters; never zero so a single requester still synthesises.
   function automatic int f_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/afifo_wr_arb_if.sv
// ============================================================================
// afifo_wr_arb_if : requester-side and FIFO-side signals of the write arbiter
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface afifo_wr_arb_if
   import afifo_pkg::*;
#(
   parameter int NREQ = c_NREQ,
   parameter int DW   = c_DW
) ();

   localparam int OW = f_idx_w(NREQ);

   logic                 arb_en;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      ack;
   logic                 full;
   logic                 wr_en;
   logic [DW-1:0]        wr_data;
   logic [OW-1:0]        owner;
   logic                 busy;
   logic [15:0]          wr_count;

   modport slave (
      input  arb_en, req, req_data, full,
      output ack, wr_en, wr_data, owner, busy, wr_count
   );

   modport master (
      output arb_en, req, req_data, full,
      input  ack, wr_en, wr_data, owner, busy, wr_count
   );

endinterface

`default_nettype wire

// File: rtl/afifo_rr_pick.sv
// ============================================================================
// afifo_rr_pick : combinational round-robin selector, last owner lowest priority
// Revision      : 1.0
// ============================================================================
`default_nettype none

module afifo_rr_pick
   import afifo_pkg::*;
#(
   parameter int NREQ = c_NREQ,
   parameter int OW   = f_idx_w(c_NREQ)
) (
   input  wire logic [NREQ-1:0] i_req,
   input  wire logic [OW-1:0]   i_last_owner,
   output logic      [OW-1:0]   o_pick,
   output logic                 o_any_req
);

   int w_idx;

   // Scan from farthest to nearest offset so the nearest set bit after last_owner wins.
   always_comb begin
      o_pick    = '0;
      o_any_req = |i_req;
      w_idx     = 0;
      for (int i = NREQ; i >= 1; i--) begin
         w_idx = (int'(i_last_owner) + i) % NREQ;
         if (i_req[w_idx]) begin
            o_pick = OW'(w_idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/afifo_wr_arb.sv
// ============================================================================
// afifo_wr_arb : burst-limited round-robin arbiter muxing NREQ writers onto a FIFO
// Revision     : 1.0
// ============================================================================
`default_nettype none

module afifo_wr_arb
   import afifo_pkg::*;
#(
   parameter int NREQ  = c_NREQ,
   parameter int DW    = c_DW,
   parameter int BURST = c_BURST
) (
   input  wire logic       clk_wr,
   input  wire logic       rst,
   afifo_wr_arb_if.slave   bus
);

   localparam int OW = f_idx_w(NREQ);
   localparam int BW = 4;

   state_t           r_state, w_state_nxt;
   logic [OW-1:0]    r_owner, w_owner_nxt;
   logic [OW-1:0]    r_last,  w_last_nxt;
   logic [BW-1:0]    r_beat,  w_beat_nxt;
   logic [15:0]      r_wr_count;

   logic             w_busy;
   logic             w_req_own;
   logic             w_wr_en;
   logic             w_exit;
   logic [OW-1:0]    w_base;
   logic [OW-1:0]    w_pick;
   logic             w_any;

   assign w_busy    = (r_state == BUSY);
   assign w_req_own = bus.req[r_owner];
   assign w_wr_en   = w_busy && w_req_own && !bus.full;
   assign w_exit    = w_busy && !bus.full && (!w_req_own || (r_beat == BW'(BURST - 1)));

   // While busy the re-pick happens at burst exit, where the current owner becomes last_owner.
   assign w_base = w_busy ? r_owner : r_last;

   afifo_rr_pick #(
      .NREQ (NREQ),
      .OW   (OW)
   ) u_rr_pick (
      .i_req        (bus.req),
      .i_last_owner (w_base),
      .o_pick       (w_pick),
      .o_any_req    (w_any)
   );

   always_ff @(posedge clk_wr or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_last     <= OW'(NREQ - 1);
         r_beat     <= '0;
         r_wr_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_beat  <= w_beat_nxt;
         if (w_wr_en) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_beat_nxt  = r_beat;
      case (r_state)
         IDLE: begin
            if (bus.arb_en && w_any) begin
               w_owner_nxt = w_pick;
               w_beat_nxt  = '0;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (w_exit) begin
               w_last_nxt = r_owner;
               w_beat_nxt = '0;
               if (bus.arb_en && w_any) begin
                  w_owner_nxt = w_pick;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_wr_en) begin
               w_beat_nxt = r_beat + BW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.ack          = '0;
      bus.ack[r_owner] = w_wr_en;
   end

   assign bus.wr_en    = w_wr_en;
   assign bus.wr_data  = w_busy ? bus.req_data[int'(r_owner)*DW +: DW] : '0;
   assign bus.owner    = r_owner;
   assign bus.busy     = w_busy;
   assign bus.wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_afifo_wr_arb.sv
// ============================================================================
// tb_afifo_wr_arb : directed self-checking bench for the FIFO write arbiter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_afifo_wr_arb;

   logic clk_wr;
   logic rst;
   int   n_chk;
   int   n_pass;

   afifo_wr_arb_if #(.NREQ(4), .DW(8)) bus ();

   afifo_wr_arb #(
      .NREQ  (4),
      .DW    (8),
      .BURST (4)
   ) u_dut (
      .clk_wr (clk_wr),
      .rst    (rst),
      .bus    (bus.slave)
   );

   initial clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_wr);
      #1;
   endtask

   task automatic set_data(input int k, input logic [7:0] v);
      bus.req_data[k*8 +: 8] = v;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.req    = '0;
      bus.full   = 1'b0;
      bus.arb_en = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      n_chk        = 0;
      n_pass       = 0;
      rst          = 1'b1;
      bus.arb_en   = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.full     = 1'b0;
      cyc();
      cyc();
      #1;
      chk("rst_busy",  32'(bus.busy),     32'd0);
      chk("rst_wren",  32'(bus.wr_en),    32'd0);
      chk("rst_ack",   32'(bus.ack),      32'd0);
      chk("rst_owner", 32'(bus.owner),    32'd0);
      chk("rst_data",  32'(bus.wr_data),  32'd0);
      chk("rst_count", 32'(bus.wr_count), 32'd0);

      // Lone requester 0: one IDLE cycle, then 6 back-to-back words across a re-grant
      rst     = 1'b0;
      bus.req = 4'b0001;
      set_data(0, 8'hA0);
      #1;
      chk("A_idle_busy", 32'(bus.busy),  32'd0);
      chk("A_idle_wren", 32'(bus.wr_en), 32'd0);
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (k > 0) set_data(0, 8'(8'hA0 + k));
         #1;
         chk("A_wren", 32'(bus.wr_en),   32'd1);
         chk("A_ack",  32'(bus.ack),     32'b0001);
         chk("A_data", 32'(bus.wr_data), 32'(8'hA0 + k));
      end
      cyc();
      bus.req = '0;
      #1;
      chk("A_count", 32'(bus.wr_count), 32'd6);
      chk("A_nowr",  32'(bus.wr_en),    32'd0);
      cyc();
      #1;
      chk("A_exit_idle", 32'(bus.busy), 32'd0);

      // All four requesting: 4 words each in order 0,1,2,3,0
      do_reset();
      for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 * (k + 1)));
      bus.req = 4'b1111;
      cyc();
      for (int n = 0; n < 20; n++) begin
         if (n > 0) cyc();
         #1;
         chk("B_owner", 32'(bus.owner),   32'((n / 4) % 4));
         chk("B_ack",   32'(bus.ack),     32'(1) << ((n / 4) % 4));
         chk("B_data",  32'(bus.wr_data), 32'(8'h10 * (((n / 4) % 4) + 1)));
      end
      cyc();
      bus.req = '0;
      #1;
      chk("B_count", 32'(bus.wr_count), 32'd20);
      cyc();
      cyc();

      // Owner 2 stalled by full at beat 1, then finishes 3 more words before owner 1
      do_reset();
      set_data(1, 8'hC1);
      set_data(2, 8'hC2);
      bus.req = 4'b0100;
      cyc();
      #1;
      chk("C_owner", 32'(bus.owner), 32'd2);
      chk("C_wren",  32'(bus.wr_en), 32'd1);
      cyc();
      bus.full = 1'b1;
      bus.req  = 4'b0110;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cyc();
         #1;
         chk("C_full_wren",  32'(bus.wr_en), 32'd0);
         chk("C_full_ack",   32'(bus.ack),   32'd0);
         chk("C_full_owner", 32'(bus.owner), 32'd2);
      end
      cyc();
      bus.full = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) cyc();
         #1;
         chk("C_res_owner", 32'(bus.owner), 32'd2);
         chk("C_res_wren",  32'(bus.wr_en), 32'd1);
      end
      cyc();
      #1;
      chk("C_next_owner", 32'(bus.owner),   32'd1);
      chk("C_next_data",  32'(bus.wr_data), 32'hC1);
      bus.req = '0;
      cyc();
      cyc();

      // Owner 1 drops req after two words; owner 3 takes over with no IDLE gap
      do_reset();
      set_data(1, 8'hD1);
      set_data(3, 8'hD3);
      bus.req = 4'b0010;
      cyc();
      #1;
      chk("D_owner1", 32'(bus.owner), 32'd1);
      cyc();
      #1;
      chk("D_wr2", 32'(bus.wr_en), 32'd1);
      cyc();
      bus.req = 4'b1000;
      #1;
      chk("D_drop_wren", 32'(bus.wr_en), 32'd0);
      chk("D_drop_busy", 32'(bus.busy),  32'd1);
      cyc();
      #1;
      chk("D_owner3", 32'(bus.owner),   32'd3);
      chk("D_busy",   32'(bus.busy),    32'd1);
      chk("D_data",   32'(bus.wr_data), 32'hD3);
      bus.req = '0;
      cyc();
      cyc();

      // Reset mid-burst with owner 3
      do_reset();
      set_data(3, 8'hE3);
      bus.req = 4'b1000;
      cyc();
      #1;
      chk("E_owner3", 32'(bus.owner), 32'd3);
      cyc();
      rst = 1'b1;
      #1;
      chk("E_rst_wren",  32'(bus.wr_en),    32'd0);
      chk("E_rst_ack",   32'(bus.ack),      32'd0);
      chk("E_rst_count", 32'(bus.wr_count), 32'd0);
      chk("E_rst_owner", 32'(bus.owner),    32'd0);
      chk("E_rst_data",  32'(bus.wr_data),  32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("E_idle", 32'(bus.busy), 32'd0);
      cyc();
      #1;
      chk("E_regrant_owner", 32'(bus.owner), 32'd3);
      chk("E_regrant_wren",  32'(bus.wr_en), 32'd1);
      bus.req = '0;
      cyc();
      cyc();

      // arb_en low mid-burst: burst completes, next grant waits for arb_en
      do_reset();
      set_data(0, 8'hF0);
      set_data(1, 8'hF1);
      bus.req = 4'b0011;
      cyc();
      bus.arb_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc();
         #1;
         chk("F_owner0", 32'(bus.owner), 32'd0);
         chk("F_wren",   32'(bus.wr_en), 32'd1);
      end
      cyc();
      #1;
      chk("F_idle_busy", 32'(bus.busy),  32'd0);
      chk("F_idle_wren", 32'(bus.wr_en), 32'd0);
      cyc();
      #1;
      chk("F_blocked", 32'(bus.busy), 32'd0);
      bus.arb_en = 1'b1;
      #1;
      chk("F_en_idle", 32'(bus.busy), 32'd0);
      cyc();
      #1;
      chk("F_owner1", 32'(bus.owner),   32'd1);
      chk("F_wren1",  32'(bus.wr_en),   32'd1);
      chk("F_data1",  32'(bus.wr_data), 32'hF1);
      bus.req = '0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
